// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_arb_pkg;

    typedef enum logic {IDLE, BUS} wb_arb_state_t;

    localparam int MAX_M = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester strictly after 'last' in cyclic order; 'last' itself is scanned last.
    function automatic int rr_next(input logic [MAX_M-1:0] req, input int last, input int n);
        int cand;
        rr_next = last;
        for (int k = n; k >= 1; k--) begin
            cand = last + k;
            if (cand >= n) cand = cand - n;
            if (req[cand]) rr_next = cand;
        end
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Arbiter-facing bundle of the shared Wishbone bus; slave = arbiter, master = interconnect.
interface wb_rr_arbiter_if #(
    parameter int numm = 2,
    parameter int iw   = wb_arb_pkg::idx_width(numm)
);
    logic [numm-1:0] cyc;
    logic            stb;
    logic            stall;
    logic            ack;
    logic            err;
    logic [numm-1:0] gnt;
    logic [iw-1:0]   gnt_idx;
    logic            busy;
    logic            stall_o;
    logic            timeout_err;

    modport slave (
        input  cyc, stb, stall, ack, err,
        output gnt, gnt_idx, busy, stall_o, timeout_err
    );

    modport master (
        output cyc, stb, stall, ack, err,
        input  gnt, gnt_idx, busy, stall_o, timeout_err
    );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational cyclic priority encoder: request vector + last-owner pointer -> one-hot, index, valid.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int numm = 2,
    parameter int iw   = idx_width(numm)
) (
    input  logic [numm-1:0] req,
    input  logic [iw-1:0]   last,
    output logic [numm-1:0] onehot,
    output logic [iw-1:0]   idx,
    output logic            valid
);

    logic [MAX_M-1:0] req_ext;
    int               sel;

    always_comb begin
        req_ext             = '0;
        req_ext[numm-1:0]   = req;
        sel                 = rr_next(req_ext, int'(last), numm);
        valid               = |req;
        idx                 = iw'(sel);
        onehot              = '0;
        if (valid) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin owner arbiter with outstanding-request tracking for the shared Wishbone bus.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int numm    = 2,
    parameter int outw    = 3,
    parameter int timeout = 255
) (
    input  logic            clk,
    input  logic            rst,
    wb_rr_arbiter_if.slave  bus
);

    localparam int              IW      = idx_width(numm);
    localparam logic [outw-1:0] OUT_MAX = '1;

    wb_arb_state_t   state, state_nx;
    logic [numm-1:0] gnt_r, gnt_nx;
    logic [IW-1:0]   idx_r, idx_nx;
    logic [IW-1:0]   last_r, last_nx;
    logic [outw-1:0] out_r, out_nx;

    logic [numm-1:0] cyc_v;
    logic [numm-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            owner_cyc;
    logic            busy;
    logic            stall_o;
    logic            accept;
    logic            complete;
    logic            fire;
    logic            to_pulse;

    assign cyc_v     = bus.cyc;
    assign busy      = (state == BUS);
    assign owner_cyc = |(cyc_v & gnt_r);
    assign stall_o   = (out_r == OUT_MAX) & busy;
    assign accept    = bus.stb & ~bus.stall & ~stall_o;
    assign complete  = bus.ack | bus.err | to_pulse;

    wb_rr_pick #(.numm(numm), .iw(IW)) u_pick (
        .req    (cyc_v),
        .last   (last_r),
        .onehot (pick_gnt),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(timeout + 1);

    logic [WDW-1:0] wd_r, wd_nx;
    logic           to_r;

    // Counts stalled-response cycles of the current owner; any progress or ownership change restarts it.
    always_comb begin
        wd_nx = wd_r;
        fire  = 1'b0;
        if (busy && owner_cyc) begin
            if (bus.ack || bus.err || accept) begin
                wd_nx = '0;
            end else if (out_r != '0) begin
                if (int'(wd_r) + 1 >= timeout) begin
                    fire  = 1'b1;
                    wd_nx = '0;
                end else begin
                    wd_nx = wd_r + 1'b1;
                end
            end
        end else begin
            wd_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r <= '0;
            to_r <= 1'b0;
        end else begin
            wd_r <= wd_nx;
            to_r <= fire;
        end
    end

    assign to_pulse = to_r;
`else
    assign fire     = 1'b0;
    assign to_pulse = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_r;
        idx_nx   = idx_r;
        last_nx  = last_r;
        out_nx   = out_r;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_nx   = pick_gnt;
                    idx_nx   = pick_idx;
                    last_nx  = pick_idx;
                    state_nx = BUS;
                end
            end
            BUS: begin
                // A released cycle aborts whatever is in flight; the next requester takes over without an idle gap.
                if (!owner_cyc) begin
                    out_nx = '0;
                    if (pick_valid) begin
                        gnt_nx  = pick_gnt;
                        idx_nx  = pick_idx;
                        last_nx = pick_idx;
                    end else begin
                        gnt_nx   = '0;
                        state_nx = IDLE;
                    end
                end else if (fire) begin
                    out_nx = '0;
                end else if (accept && !complete) begin
                    out_nx = out_r + 1'b1;
                end else if (complete && !accept && out_r != '0) begin
                    out_nx = out_r - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_r  <= '0;
            idx_r  <= '0;
            last_r <= IW'(numm - 1);
            out_r  <= '0;
        end else begin
            state  <= state_nx;
            gnt_r  <= gnt_nx;
            idx_r  <= idx_nx;
            last_r <= last_nx;
            out_r  <= out_nx;
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.gnt_idx     = idx_r;
    assign bus.busy        = busy;
    assign bus.stall_o     = stall_o;
    assign bus.timeout_err = to_pulse;

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_r));
    a_gnt_hold:    assert property (@(posedge clk) (!rst && busy && owner_cyc) |=> $stable(gnt_r));
    a_no_underflw: assert property (@(posedge clk) (!rst && out_r == '0) |=> (out_r <= outw'(1)));

endmodule
